// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin hold arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   PTR_W/CNT_W : pointer and hold-counter widths for the default
//                 configuration (N=4, MAX_HOLD=16)
//   ptr_width() / cnt_width() : the same widths for any configuration
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 4;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   elig  : candidate vector, one bit per requester
//   ptr   : index searched first; search continues ptr+1, ... mod N
//   found : at least one candidate present
//   idx   : index of the first candidate found (0 when none)
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  int unsigned pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && elig[pos]) begin
        found = 1'b1;
        idx   = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a per-ownership hold limit.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : request level per requester
//   rel     : release strobe, only the owner's bit is honoured
//   gnt     : registered one-hot grant, zero when idle
//   gnt_id  : registered owner index, zero when idle
//   busy    : high while a grant is held
//   timeout : one-cycle pulse after a forced revoke
// A requester revoked by timeout stays masked until it drops req.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned PW = ptr_width(N);
  localparam int unsigned CW = cnt_width(MAX_HOLD);

  arb_state_t     state;
  logic [PW-1:0]  owner;
  logic [PW-1:0]  ptr;
  logic [N-1:0]   mask;
  logic [CW-1:0]  hold_cnt;

  logic [N-1:0]   elig;
  logic           pick_found;
  logic [PW-1:0]  pick_idx;
  logic [N-1:0]   pick_onehot;
  logic           end_grant;
  logic           hold_last;
  logic [N-1:0]   mask_set;
  logic [PW-1:0]  ptr_after;

  assign elig      = req & ~mask;
  assign end_grant = rel[owner] | ~req[owner];
  assign hold_last = (hold_cnt == CW'(MAX_HOLD - 1));
  assign ptr_after = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;

  rr_pick #(
    .N     (N),
    .PTR_W (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // Release wins over the final hold cycle, so the mask is only set on a
  // genuine forced revoke.
  always_comb begin
    mask_set = '0;
    if (state == GRANT && !end_grant && hold_last) mask_set[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      mask     <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      // A dropped request clears the mask even if it is set this cycle.
      mask    <= (mask | mask_set) & req;
      if (state == IDLE) begin
        if (pick_found) begin
          state    <= GRANT;
          owner    <= pick_idx;
          hold_cnt <= '0;
          gnt      <= pick_onehot;
          gnt_id   <= pick_idx;
          busy     <= 1'b1;
        end
      end else begin
        if (end_grant || hold_last) begin
          state   <= IDLE;
          ptr     <= ptr_after;
          gnt     <= '0;
          gnt_id  <= '0;
          busy    <= 1'b0;
          timeout <= ~end_grant;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
module tb_rr_hold_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] rel = '0;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: who owns the resource, for how many cycles,
  // where the round-robin search starts, and who is locked out.
  bit m_busy;
  int m_owner;
  int m_cycles;
  int m_next;
  bit m_locked [NREQ];
  bit m_timeout;

  rr_hold_arbiter #(
    .N        (NREQ),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cycles = 0; m_next = 0; m_timeout = 0;
    for (int i = 0; i < NREQ; i++) m_locked[i] = 0;
  endtask

  task automatic model_clock();
    m_timeout = 0;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_next + k) % NREQ;
        if (!m_busy && req[i] && !m_locked[i]) begin
          m_busy = 1; m_owner = i; m_cycles = 1;
        end
      end
    end else if (rel[m_owner] || !req[m_owner]) begin
      m_busy = 0; m_next = (m_owner + 1) % NREQ;
    end else if (m_cycles == HOLD) begin
      m_busy = 0; m_next = (m_owner + 1) % NREQ;
      m_timeout = 1; m_locked[m_owner] = 1;
    end else begin
      m_cycles++;
    end
    for (int i = 0; i < NREQ; i++) if (!req[i]) m_locked[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_clock();
  endtask

  task automatic do_reset();
    req = '0; rel = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tests_run++; if (gnt_id !== 2'd0) begin tests_failed++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    req = 4'b0100;
    step();
    tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL areset_pre_gnt got=%b exp=0100", gnt); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL areset_gnt got=%b exp=0000", gnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL areset_busy got=%b exp=0", busy); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL areset_timeout got=%b exp=0", timeout); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    req = 4'b1111;
    step();
    tests_run++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin tests_failed++; $display("FAIL areset_regrant got=%b/%0d exp=0001/0", gnt, gnt_id); end
    req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    step();
    tests_run++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin tests_failed++; $display("FAIL single_c1 got=%b/%0d exp=0010/1", gnt, gnt_id); end
    step();
    tests_run++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin tests_failed++; $display("FAIL single_c2 got=%b/%0d exp=0010/1", gnt, gnt_id); end
    rel = 4'b0010;
    step();
    rel = '0;
    tests_run++; if (gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_c3 got=%b busy=%b exp=0000 busy=0", gnt, busy); end
    req = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [NREQ-1:0] exp_g;
      exp_g = 4'(1 << (k % NREQ));
      step();
      tests_run++; if (gnt !== exp_g || gnt_id !== 2'(k % NREQ) || busy !== 1'b1) begin
        tests_failed++; $display("FAIL fair_grant%0d got=%b/%0d exp=%b/%0d", k, gnt, gnt_id, exp_g, k % NREQ);
      end
      rel = exp_g;
      step();
      rel = '0;
      tests_run++; if (gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL fair_idle%0d got=%b exp=0000", k, gnt); end
    end
    req = '0;
  endtask

  task automatic test_timeout_mask();
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < HOLD; c++) begin
      step();
      tests_run++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin tests_failed++; $display("FAIL hold_c%0d got=%b to=%b exp=0001 to=0", c, gnt, timeout); end
    end
    step();
    tests_run++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin tests_failed++; $display("FAIL revoke got=%b to=%b exp=0000 to=1", gnt, timeout); end
    step();
    tests_run++; if (gnt !== 4'b0100 || timeout !== 1'b0) begin tests_failed++; $display("FAIL after_to_grant got=%b to=%b exp=0100 to=0", gnt, timeout); end
    req = 4'b0001; rel = 4'b0100;
    step();
    rel = '0;
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL rel2 got=%b exp=0000", gnt); end
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL masked%0d got=%b exp=0000", c, gnt); end
    end
    req = 4'b0000;
    step();
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL unmask_idle got=%b exp=0000", gnt); end
    req = 4'b0001;
    step();
    tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL unmask_regrant got=%b exp=0001", gnt); end
    req = '0;
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < HOLD; c++) begin
      step();
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL coll_hold%0d got=%b exp=0001", c, gnt); end
    end
    rel = 4'b0001;
    step();
    rel = '0;
    tests_run++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin tests_failed++; $display("FAIL coll_release got=%b to=%b exp=0000 to=0", gnt, timeout); end
    tests_run++; if (dut.mask[0] !== 1'b0) begin tests_failed++; $display("FAIL coll_mask got=%b exp=0", dut.mask[0]); end
    step();
    tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL coll_regrant got=%b exp=0001", gnt); end
    req = '0;
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b1000;
    step();
    tests_run++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin tests_failed++; $display("FAIL drop_grant got=%b/%0d exp=1000/3", gnt, gnt_id); end
    step();
    req = 4'b0000;
    step();
    tests_run++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin tests_failed++; $display("FAIL drop_idle got=%b to=%b exp=0000 to=0", gnt, timeout); end
    tests_run++; if (dut.ptr !== 2'd0) begin tests_failed++; $display("FAIL drop_ptr got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [NREQ-1:0] exp_g;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        rel[i] = ($urandom_range(0, 9) == 0);
      end
      step();
      exp_g = m_busy ? 4'(1 << m_owner) : 4'b0000;
      tests_run++;
      if (gnt !== exp_g || gnt_id !== 2'(m_busy ? m_owner : 0) || busy !== m_busy || timeout !== m_timeout) begin
        tests_failed++;
        $display("FAIL rand_c%0d got gnt=%b id=%0d busy=%b to=%b exp gnt=%b id=%0d busy=%b to=%b",
                 c, gnt, gnt_id, busy, timeout, exp_g, m_busy ? m_owner : 0, m_busy, m_timeout);
      end
    end
    req = '0; rel = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_timeout_mask();
    test_collision();
    test_req_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
